// File: rtl/mips_defs.sv
// Shared encodings for the MIPS pipeline: opcodes, functs, ALU operations,
// next-PC source selection and the bubble instruction.
package mips_defs;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALUC_ADD = 4'd0,
    ALUC_SUB = 4'd1,
    ALUC_AND = 4'd2,
    ALUC_OR  = 4'd3,
    ALUC_XOR = 4'd4,
    ALUC_LUI = 4'd5,
    ALUC_SLT = 4'd6,
    ALUC_SLL = 4'd7,
    ALUC_SRL = 4'd8,
    ALUC_SRA = 4'd9
  } aluc_t;

  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'b00,
    PCSRC_BPC = 2'b01,
    PCSRC_JPC = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_t;

endpackage

// File: rtl/regfile32.sv
// Two-read, one-write register file; r0 reads as zero and a same-cycle
// write is visible on the read ports.
module regfile32 #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] d,
  output logic [31:0] qa,
  output logic [31:0] qb
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we && wn != '0) begin
      mem[wn] <= d;
    end
  end

  always_comb begin
    qa = '0;
    qb = '0;
    if (ra != '0) qa = (we && wn == ra) ? d : mem[ra];
    if (rb != '0) qb = (we && wn == rb) ? d : mem[rb];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, control decode, operand
// forwarding, load-use interlock and branch/jump resolution.
module id_stage #(
  parameter logic [31:0] NOP_INST = mips_defs::NOP_INST,
  parameter int unsigned RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc4,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rn,
  input  logic [31:0] wb_d,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic [31:0] ex_alu,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_rn,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_mdata,
  output logic        stall,
  output logic [1:0]  pcsource,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic        id_wreg,
  output logic        id_m2reg,
  output logic        id_wmem,
  output logic        id_aluimm,
  output logic        id_shift,
  output logic        id_jal,
  output logic [3:0]  id_aluc,
  output logic [4:0]  id_rn,
  output logic [31:0] id_da,
  output logic [31:0] id_db,
  output logic [31:0] id_imm,
  output logic [31:0] id_pc4
);

  import mips_defs::*;

  logic [31:0] inst, pc4;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] qa, qb;
  logic        flush, taken;
  logic        wreg, wmem, regrt, sext, use_rs, use_rt;
  logic        is_beq, is_bne, is_j, is_jr;
  aluc_t       aluc;
  pcsrc_t      pcsel;

  assign op  = inst[31:26];
  assign rs  = inst[25:21];
  assign rt  = inst[20:16];
  assign rd  = inst[15:11];
  assign fn  = inst[5:0];
  assign imm = inst[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= NOP_INST;
      pc4  <= '0;
    end else if (!stall) begin
      inst <= flush ? NOP_INST : if_inst;
      pc4  <= if_pc4;
    end
  end

  regfile32 #(.DEPTH(RF_DEPTH)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra  (rs),
    .rb  (rt),
    .we  (wb_wreg),
    .wn  (wb_rn),
    .d   (wb_d),
    .qa  (qa),
    .qb  (qb)
  );

  // NOP_INST is itself an encoding (sll r0,r0,0) but must decode as a pure bubble.
  always_comb begin
    wreg      = 1'b0;
    id_m2reg  = 1'b0;
    wmem      = 1'b0;
    id_aluimm = 1'b0;
    id_shift  = 1'b0;
    id_jal    = 1'b0;
    regrt     = 1'b0;
    sext      = 1'b1;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    aluc      = ALUC_ADD;
    if (inst != NOP_INST) begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_SUB:  aluc = ALUC_SUB;
            FN_AND:  aluc = ALUC_AND;
            FN_OR:   aluc = ALUC_OR;
            FN_XOR:  aluc = ALUC_XOR;
            FN_SLT:  aluc = ALUC_SLT;
            FN_SLL:  aluc = ALUC_SLL;
            FN_SRL:  aluc = ALUC_SRL;
            FN_SRA:  aluc = ALUC_SRA;
            default: aluc = ALUC_ADD;
          endcase
          case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
              wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              wreg = 1'b1; id_shift = 1'b1; use_rt = 1'b1;
            end
            FN_JR: begin
              is_jr = 1'b1; use_rs = 1'b1;
            end
            default: ;
          endcase
        end
        OP_ADDI: begin
          wreg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
        end
        OP_ANDI: begin
          wreg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
          sext = 1'b0; aluc = ALUC_AND;
        end
        OP_ORI: begin
          wreg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
          sext = 1'b0; aluc = ALUC_OR;
        end
        OP_XORI: begin
          wreg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
          sext = 1'b0; aluc = ALUC_XOR;
        end
        OP_LUI: begin
          wreg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1; aluc = ALUC_LUI;
        end
        OP_LW: begin
          wreg = 1'b1; id_m2reg = 1'b1; id_aluimm = 1'b1; regrt = 1'b1;
          use_rs = 1'b1;
        end
        OP_SW: begin
          wmem = 1'b1; id_aluimm = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        end
        OP_BEQ: begin
          is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = ALUC_SUB;
        end
        OP_BNE: begin
          is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = ALUC_SUB;
        end
        OP_J: is_j = 1'b1;
        OP_JAL: begin
          is_j = 1'b1; id_jal = 1'b1; wreg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rfv,
    input logic        exw,
    input logic        exl,
    input logic [4:0]  exn,
    input logic [31:0] exa,
    input logic        mw,
    input logic        ml,
    input logic [4:0]  mn,
    input logic [31:0] ma,
    input logic [31:0] md
  );
    if (exw && !exl && exn == src && src != '0) return exa;
    if (mw && mn == src && src != '0) return ml ? md : ma;
    return rfv;
  endfunction

  assign id_da = fwd(rs, qa, ex_wreg, ex_m2reg, ex_rn, ex_alu,
                     mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_mdata);
  assign id_db = fwd(rt, qb, ex_wreg, ex_m2reg, ex_rn, ex_alu,
                     mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_mdata);

  // A stall masks redirection, so the branch is re-resolved once the load data forwards.
  always_comb begin
    stall = ex_wreg && ex_m2reg && ex_rn != '0 &&
            ((use_rs && ex_rn == rs) || (use_rt && ex_rn == rt));
    taken = (is_beq && id_da == id_db) || (is_bne && id_da != id_db);
    pcsel = PCSRC_PC4;
    if (!stall) begin
      if (is_jr)      pcsel = PCSRC_JR;
      else if (is_j)  pcsel = PCSRC_JPC;
      else if (taken) pcsel = PCSRC_BPC;
    end
  end

  assign pcsource = pcsel;
  assign flush    = pcsel != PCSRC_PC4;
  assign bpc      = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jpc      = {pc4[31:28], inst[25:0], 2'b00};
  assign id_imm   = sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  assign id_rn    = id_jal ? 5'd31 : (regrt ? rt : rd);
  assign id_wreg  = wreg && !stall;
  assign id_wmem  = wmem && !stall;
  assign id_aluc  = aluc;
  assign id_pc4   = pc4;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against a mnemonic-level model.
module tb_id_stage;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_inst, if_pc4, wb_d, ex_alu, mem_alu, mem_mdata;
  logic        wb_wreg, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [4:0]  wb_rn, ex_rn, mem_rn;
  logic        stall, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_jal;
  logic [1:0]  pcsource;
  logic [3:0]  id_aluc;
  logic [4:0]  id_rn;
  logic [31:0] bpc, jpc, id_da, id_db, id_imm, id_pc4;

  int checks = 0;
  int failures = 0;

  id_stage #(.NOP_INST(32'h0000_0000), .RF_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc4(if_pc4),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .mem_alu(mem_alu), .mem_mdata(mem_mdata),
    .stall(stall), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluimm(id_aluimm), .id_shift(id_shift), .id_jal(id_jal),
    .id_aluc(id_aluc), .id_rn(id_rn), .id_da(id_da), .id_db(id_db),
    .id_imm(id_imm), .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL, K_SRA, K_JR,
    K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_UNK
  } kind_t;

  typedef struct packed {
    logic       wr, ld, st, imm, sh, jl, urs, urt, zx, dst_rt, alu_ok;
    logic [3:0] alu;
  } props_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_inst, m_pc4;
  logic        m_stall, m_flush;

  function automatic logic [31:0] rtype(logic [4:0] s, t, d, sa, logic [5:0] f);
    return {6'd0, s, t, d, sa, f};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] o, logic [4:0] s, t, logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] build(kind_t k, logic [4:0] s, t, d, logic [15:0] im, logic [25:0] ad);
    case (k)
      K_ADD:  return rtype(s, t, d, 5'd0, 6'h20);
      K_SUB:  return rtype(s, t, d, 5'd0, 6'h22);
      K_AND:  return rtype(s, t, d, 5'd0, 6'h24);
      K_OR:   return rtype(s, t, d, 5'd0, 6'h25);
      K_XOR:  return rtype(s, t, d, 5'd0, 6'h26);
      K_SLT:  return rtype(s, t, d, 5'd0, 6'h2a);
      K_SLL:  return rtype(s, t, d, im[4:0], 6'h00);
      K_SRL:  return rtype(s, t, d, im[4:0], 6'h02);
      K_SRA:  return rtype(s, t, d, im[4:0], 6'h03);
      K_JR:   return rtype(s, 5'd0, 5'd0, 5'd0, 6'h08);
      K_ADDI: return itype(6'h08, s, t, im);
      K_ANDI: return itype(6'h0c, s, t, im);
      K_ORI:  return itype(6'h0d, s, t, im);
      K_XORI: return itype(6'h0e, s, t, im);
      K_LUI:  return itype(6'h0f, s, t, im);
      K_LW:   return itype(6'h23, s, t, im);
      K_SW:   return itype(6'h2b, s, t, im);
      K_BEQ:  return itype(6'h04, s, t, im);
      K_BNE:  return itype(6'h05, s, t, im);
      K_J:    return {6'h02, ad};
      K_JAL:  return {6'h03, ad};
      K_UNK:  return im[0] ? itype(6'h3f, s, t, im) : rtype(s, t, d, 5'd0, 6'h3f);
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic kind_t classify(logic [31:0] i);
    if (i == 32'h0000_0000) return K_NOP;
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20: return K_ADD;
               6'h22: return K_SUB;
               6'h24: return K_AND;
               6'h25: return K_OR;
               6'h26: return K_XOR;
               6'h2a: return K_SLT;
               6'h00: return K_SLL;
               6'h02: return K_SRL;
               6'h03: return K_SRA;
               6'h08: return K_JR;
               default: return K_UNK;
             endcase
      6'h08: return K_ADDI;
      6'h0c: return K_ANDI;
      6'h0d: return K_ORI;
      6'h0e: return K_XORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_UNK;
    endcase
  endfunction

  // wr ld st imm sh jl urs urt zx dst_rt alu_ok alu
  function automatic props_t props(kind_t k);
    props_t p = '0;
    case (k)
      K_ADD:  p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_ADD};
      K_SUB:  p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_SUB};
      K_AND:  p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_AND};
      K_OR:   p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_OR};
      K_XOR:  p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_XOR};
      K_SLT:  p = '{1,0,0,0,0,0,1,1,0,0,1,ALUC_SLT};
      K_SLL:  p = '{1,0,0,0,1,0,0,1,0,0,1,ALUC_SLL};
      K_SRL:  p = '{1,0,0,0,1,0,0,1,0,0,1,ALUC_SRL};
      K_SRA:  p = '{1,0,0,0,1,0,0,1,0,0,1,ALUC_SRA};
      K_JR:   p = '{0,0,0,0,0,0,1,0,0,0,0,ALUC_ADD};
      K_ADDI: p = '{1,0,0,1,0,0,1,0,0,1,1,ALUC_ADD};
      K_ANDI: p = '{1,0,0,1,0,0,1,0,1,1,1,ALUC_AND};
      K_ORI:  p = '{1,0,0,1,0,0,1,0,1,1,1,ALUC_OR};
      K_XORI: p = '{1,0,0,1,0,0,1,0,1,1,1,ALUC_XOR};
      K_LUI:  p = '{1,0,0,1,0,0,0,0,0,1,1,ALUC_LUI};
      K_LW:   p = '{1,1,0,1,0,0,1,0,0,1,1,ALUC_ADD};
      K_SW:   p = '{0,0,1,1,0,0,1,1,0,0,1,ALUC_ADD};
      K_BEQ:  p = '{0,0,0,0,0,0,1,1,0,0,0,ALUC_ADD};
      K_BNE:  p = '{0,0,0,0,0,0,1,1,0,0,0,ALUC_ADD};
      K_JAL:  p = '{1,0,0,0,0,1,0,0,0,0,0,ALUC_ADD};
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(logic [4:0] src);
    if (src == 5'd0) return 32'h0;
    if (wb_wreg && wb_rn == src) return wb_d;
    return m_rf[src];
  endfunction

  function automatic logic [31:0] operand(logic [4:0] src);
    if (src != 5'd0 && ex_wreg && !ex_m2reg && ex_rn == src) return ex_alu;
    if (src != 5'd0 && mem_wreg && mem_rn == src) return mem_m2reg ? mem_mdata : mem_alu;
    return rf_read(src);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_inst = 32'h0000_0000;
    m_pc4  = 32'h0;
  endtask

  // Settle, then compare every output with the model for the current cycle.
  task automatic model_check();
    kind_t       k;
    props_t      p;
    logic [4:0]  s, t;
    logic [31:0] da, db, se, ze, e_imm;
    logic [1:0]  pcs;
    logic [4:0]  rn;
    #1;
    k  = classify(m_inst);
    p  = props(k);
    s  = m_inst[25:21];
    t  = m_inst[20:16];
    da = operand(s);
    db = operand(t);
    se = {{16{m_inst[15]}}, m_inst[15:0]};
    ze = {16'h0, m_inst[15:0]};
    e_imm = p.zx ? ze : se;
    m_stall = ex_wreg && ex_m2reg && ex_rn != 5'd0 &&
              ((p.urs && ex_rn == s) || (p.urt && ex_rn == t));
    pcs = 2'b00;
    if (!m_stall) begin
      if (k == K_JR) pcs = 2'b11;
      else if (k == K_J || k == K_JAL) pcs = 2'b10;
      else if (k == K_BEQ && da == db) pcs = 2'b01;
      else if (k == K_BNE && da != db) pcs = 2'b01;
    end
    m_flush = pcs != 2'b00;
    rn = (k == K_JAL) ? 5'd31 : (p.dst_rt ? t : m_inst[15:11]);
    chk("stall", 32'(stall), 32'(m_stall));
    chk("pcsource", 32'(pcsource), 32'(pcs));
    chk("bpc", bpc, m_pc4 + se * 4);
    chk("jpc", jpc, (m_pc4 & 32'hF000_0000) | (32'(m_inst[25:0]) * 4));
    chk("id_pc4", id_pc4, m_pc4);
    chk("id_imm", id_imm, e_imm);
    chk("id_da", id_da, da);
    chk("id_db", id_db, db);
    chk("id_wreg", 32'(id_wreg), 32'(p.wr && !m_stall));
    chk("id_wmem", 32'(id_wmem), 32'(p.st && !m_stall));
    chk("id_m2reg", 32'(id_m2reg), 32'(p.ld));
    chk("id_aluimm", 32'(id_aluimm), 32'(p.imm));
    chk("id_shift", 32'(id_shift), 32'(p.sh));
    chk("id_jal", 32'(id_jal), 32'(p.jl));
    if (p.alu_ok) chk("id_aluc", 32'(id_aluc), 32'(p.alu));
    if (p.wr) chk("id_rn", 32'(id_rn), 32'(rn));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (wb_wreg && wb_rn != 5'd0) m_rf[wb_rn] = wb_d;
    if (!m_stall) begin
      m_inst = m_flush ? 32'h0000_0000 : if_inst;
      m_pc4  = if_pc4;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_wreg = 1'b0; wb_rn = 5'd0; wb_d = 32'h0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0; ex_alu = 32'h0;
    mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_rn = 5'd0; mem_alu = 32'h0; mem_mdata = 32'h0;
  endtask

  function automatic logic [31:0] rval();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
  endfunction

  task automatic random_inputs();
    kind_t k;
    k = kind_t'(int'($urandom_range(0, 22)));
    if_inst = build(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 16'($urandom), 26'($urandom));
    if_pc4   = $urandom & 32'hFFFF_FFFC;
    wb_wreg  = 1'($urandom);
    wb_rn    = 5'($urandom_range(0, 7));
    wb_d     = rval();
    ex_wreg  = 1'($urandom);
    ex_m2reg = ($urandom_range(0, 2) == 0);
    ex_rn    = 5'($urandom_range(0, 7));
    ex_alu   = rval();
    mem_wreg  = 1'($urandom);
    mem_m2reg = 1'($urandom);
    mem_rn    = 5'($urandom_range(0, 7));
    mem_alu   = rval();
    mem_mdata = rval();
  endtask

  initial begin
    idle();
    if_inst = 32'h0; if_pc4 = 32'h0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pcsource", 32'(pcsource), 32'h0);
    chk("rst_wreg", 32'(id_wreg), 32'h0);
    chk("rst_jal", 32'(id_jal), 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_da", id_da, 32'h0);
    chk("rst_imm", id_imm, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // WB write r5, then read it through rs
    wb_wreg = 1'b1; wb_rn = 5'd5; wb_d = 32'h1234;
    if_inst = build(K_ADD, 5'd5, 5'd0, 5'd6, 16'h0, 26'h0); if_pc4 = 32'h4;
    model_check(); clock_edge();
    wb_rn = 5'd0; wb_d = 32'hDEAD;
    if_inst = build(K_ADD, 5'd0, 5'd0, 5'd6, 16'h0, 26'h0); if_pc4 = 32'h8;
    model_check();
    chk("rf_r5", id_da, 32'h1234);
    clock_edge();
    idle();
    if_inst = build(K_ADD, 5'd3, 5'd0, 5'd7, 16'h0, 26'h0); if_pc4 = 32'hC;
    model_check();
    chk("rf_r0", id_da, 32'h0);
    clock_edge();

    // EX forward, then MEM load-data forward
    ex_wreg = 1'b1; ex_rn = 5'd3; ex_alu = 32'd7;
    model_check();
    chk("fwd_ex", id_da, 32'd7);
    chk("fwd_ex_stall", 32'(stall), 32'h0);
    clock_edge();
    idle();
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd3; mem_mdata = 32'd9; mem_alu = 32'd5;
    if_inst = build(K_ADD, 5'd4, 5'd0, 5'd8, 16'h0, 26'h0); if_pc4 = 32'h14;
    model_check();
    chk("fwd_mem", id_da, 32'd9);
    clock_edge();

    // load-use stall for one cycle
    idle();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd4; ex_alu = 32'hBAD;
    if_inst = build(K_BEQ, 5'd0, 5'd0, 5'd0, 16'd3, 26'h0); if_pc4 = 32'h100;
    model_check();
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_wreg", 32'(id_wreg), 32'h0);
    clock_edge();
    idle();
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd4; mem_mdata = 32'h44;
    model_check();
    chk("lu_release", 32'(stall), 32'h0);
    chk("lu_fwd", id_da, 32'h44);
    chk("lu_held_rn", 32'(id_rn), 32'd8);
    clock_edge();

    // taken beq flushes the fetched instruction
    idle();
    if_inst = build(K_ADD, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0); if_pc4 = 32'h104;
    model_check();
    chk("beq_pcsource", 32'(pcsource), 32'h1);
    chk("beq_bpc", bpc, 32'h10C);
    clock_edge();
    if_inst = build(K_BNE, 5'd0, 5'd0, 5'd0, 16'd2, 26'h0); if_pc4 = 32'h108;
    model_check();
    chk("flush_wreg", 32'(id_wreg), 32'h0);
    chk("flush_rn", 32'(id_rn), 32'h0);
    chk("flush_pc4", id_pc4, 32'h104);
    clock_edge();
    if_inst = build(K_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10); if_pc4 = 32'h0040_0010;
    model_check();
    chk("bne_nt", 32'(pcsource), 32'h0);
    clock_edge();

    // jal
    if_inst = build(K_ADD, 5'd4, 5'd0, 5'd2, 16'h0, 26'h0); if_pc4 = 32'h44;
    model_check();
    chk("jal_jpc", jpc, 32'h0000_0040);
    chk("jal_rn", 32'(id_rn), 32'd31);
    chk("jal_pc4", id_pc4, 32'h0040_0010);
    chk("jal_pcsource", 32'(pcsource), 32'h2);
    clock_edge();
    model_check(); clock_edge();

    // reset asserted mid-stall
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd4;
    model_check();
    chk("mid_stall", 32'(stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_pc4", id_pc4, 32'h0);
    chk("mid_rst_rn", 32'(id_rn), 32'h0);
    chk("mid_rst_pcsource", 32'(pcsource), 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    if_inst = build(K_ADD, 5'd5, 5'd0, 5'd9, 16'h0, 26'h0); if_pc4 = 32'h4;
    model_check(); clock_edge();
    model_check();
    chk("rst_rf_r5", id_da, 32'h0);
    clock_edge();

    for (int n = 0; n < 600; n++) begin
      random_inputs();
      model_check();
      clock_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
